msc_bbb_host: RTL and testbench
===============================

Name: msc_bbb_host

Overview:
Host-side (initiator) engine for USB Mass Storage Bulk-Only Transport, the counterpart of the device-side msc_protocol handler. It accepts a command descriptor, serialises a 31-byte CBW onto a 32-bit bulk-OUT word stream, and moves the data phase in either direction. It then collects and validates the 13-byte CSW and reports a result. It drives msc_protocol in loopback benches and is the front end for an eventual host-mode USB controller.

Parameters:
MAX_XFER_BYTES, 65536, largest accepted dCBWDataTransferLength; larger commands are rejected at accept.
TIMEOUT_CYCLES, 1000000, watchdog limit per phase (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_tag  in  32  dCBWTag
cmd_xfer_len  in  32  dCBWDataTransferLength in bytes
cmd_dir_in  in  1  1 = data-in (flags 0x80), 0 = data-out (flags 0x00)
cmd_lun  in  3  bCBWLUN
cmd_cdb_len  in  5  bCBWCBLength, legal range 1..16
cmd_cdb  in  128  CDB; byte n is bits [8n+7:8n]
tx_data  out  32  bulk-OUT word, little-endian byte order
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink ready
rx_data  in  32  bulk-IN word
rx_valid  in  1  rx_data valid
rx_ready  out  1  engine ready for rx word
wr_data  in  32  data-out payload from client
wr_valid  in  1  payload valid
wr_ready  out  1  payload accepted
rd_data  out  32  data-in payload to client
rd_valid  out  1  payload valid
rd_ready  in  1  client ready
res_valid  out  1  one-cycle result pulse
res_code  out  2  0 = passed, 1 = failed, 2 = phase error, 3 = protocol error
res_residue  out  32  dCSWDataResidue
res_csw_status  out  8  raw bCSWStatus
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs are 0, state is IDLE, and internal counters are cleared. If reset asserts mid-transfer, the transfer is abandoned and no res_valid is issued.
- States: IDLE, CBW, DOUT, DIN, CSW, RESULT.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch all cmd_* fields.
  - Illegal command (cmd_cdb_len of 0 or greater than 16, or cmd_xfer_len greater than MAX_XFER_BYTES): go to RESULT with res_code = 3. Nothing is transmitted.
  - Legal command: go to CBW.
- CBW: emits 8 words, each advancing only on tx_valid && tx_ready.
  - Word 0: 0x43425355.
  - Word 1: tag.
  - Word 2: xfer_len.
  - Word 3: {cdb[7:0], 3'b0, cdb_len, 5'b0, lun, flags}.
  - Words 4-7: CDB bytes 1..15, lowest byte in bits [7:0]. Byte 3 of word 7 is 0x00.
  - CDB bytes at index cdb_len or above are sent as 0x00.
  - After word 7: if xfer_len = 0 go to CSW; otherwise go to DOUT or DIN per direction.
- Data phase: word count is ceil(xfer_len/4), tracked by a 30-bit down-counter.
  - DOUT: wr→tx pass-through. tx_valid = wr_valid, wr_ready = tx_ready, tx_data = wr_data. The counter decrements per transfer.
  - DIN: rx→rd pass-through with the same rules.
  - No buffering is added: zero latency, combinational valid/ready.
  - Counter reaching 0 → CSW.
- CSW: rx_ready = 1; collect 4 words.
  - Word 0 must equal 0x53425355.
  - Word 1 must equal the latched tag.
  - Word 2 is the residue.
  - Word 3 bits [7:0] are the status; bits [31:8] are ignored.
  - After word 3 go to RESULT.
- RESULT: res_valid = 1 for one cycle, then IDLE. res_code priority:
  - 3 if the signature or tag mismatches.
  - Else 2 if status = 0x02 or residue > xfer_len.
  - Else 3 if status > 0x02.
  - Else 1 if status = 0x01.
  - Else 0.
  - res_residue and res_csw_status hold their values until the next RESULT.
- Only one command is in flight at a time. cmd_ready is 0 outside IDLE, including the RESULT cycle.

Optional Feature:
MSC_HOST_TIMEOUT_EN:
- Defined: a per-phase counter clears on every state change and on every handshake in CBW, DOUT, DIN and CSW. If it reaches TIMEOUT_CYCLES, the engine goes to RESULT with res_code = 2 and res_residue = remaining bytes (word count × 4).
- Undefined: no counter exists and the engine waits indefinitely.

Test Plan:
- TEST UNIT READY (tag 0x1, len 0, cdb_len 6, opcode 0x00):
  - TX words are 0x43425355, 0x00000001, 0x00000000, 0x00060000, then 4 × 0.
  - No data phase.
  - CSW {0x53425355, 1, 0, 0} → res_code 0.
- INQUIRY data-in (len 36, cdb 12 00 00 00 24 00):
  - Word 3 = 0x12060080.
  - Exactly 9 rd transfers of 0xDEADBEEF with rd_ready toggling.
  - CSW residue 0 → res_code 0.
- WRITE_10 data-out (len 512, LBA 16):
  - 128 wr→tx words pass unchanged under random tx_ready stalls.
  - CSW status 1 → res_code 1, res_csw_status 0x01.
- Bad CSW signature 0xBADC0FFE, or a tag mismatch → res_code 3.
- Phase error cases:
  - CSW residue 600 with xfer_len 512 → res_code 2.
  - Reset asserted during DIN → outputs 0, IDLE, no res_valid.
- Illegal command (cdb_len 0, or cdb_len 17) → res_code 3, no tx_valid.
- With MSC_HOST_TIMEOUT_EN and TIMEOUT_CYCLES = 100: rx_valid is held low in CSW → res_code 2 after 100 cycles.

Source files
------------

// File: rtl/msc_bbb_host.sv
// USB Mass Storage Bulk-Only Transport host engine: CBW out, data phase, CSW in, result.
// Optional per-phase watchdog is compiled in when MSC_HOST_TIMEOUT_EN is defined.
module msc_bbb_host #(
    parameter int unsigned MAX_XFER_BYTES = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [31:0]  cmd_tag,
    input  logic [31:0]  cmd_xfer_len,
    input  logic         cmd_dir_in,
    input  logic [2:0]   cmd_lun,
    input  logic [4:0]   cmd_cdb_len,
    input  logic [127:0] cmd_cdb,
    output logic [31:0]  tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [31:0]  rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [31:0]  wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         res_valid,
    output logic [1:0]   res_code,
    output logic [31:0]  res_residue,
    output logic [7:0]   res_csw_status,
    output logic         busy
);

    localparam int unsigned CNT_W = 30;
    localparam int unsigned CDB_W = 128;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CBW    = 3'd1;
    localparam logic [2:0] S_DOUT   = 3'd2;
    localparam logic [2:0] S_DIN    = 3'd3;
    localparam logic [2:0] S_CSW    = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam logic [31:0] CBW_SIG = 32'h43425355;
    localparam logic [31:0] CSW_SIG = 32'h53425355;

    logic [2:0]       state, state_next;
    logic [2:0]       word_idx;
    logic [CNT_W-1:0] wcnt;
    logic [31:0]      tag_q, len_q, csw_residue;
    logic             dir_in_q;
    logic [2:0]       lun_q;
    logic [4:0]       cdb_len_q;
    logic [CDB_W-1:0] cdb_q, cdb_masked, cdb_tail;
    logic             sig_bad, tag_bad;
    logic             cmd_hs, cmd_legal, load_result, to_hit;
    logic [1:0]       res_code_n;
    logic [31:0]      res_residue_n, cbw_word;
    logic [7:0]       res_status_n;

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign cmd_legal = (cmd_cdb_len != 5'd0) && (cmd_cdb_len <= 5'd16) &&
                       (cmd_xfer_len <= 32'(MAX_XFER_BYTES));
    assign cdb_tail  = {8'h00, cdb_q[CDB_W-1:8]};

    // CDB bytes at or beyond bCBWCBLength go out as zero
    always_comb begin
        cdb_masked = '0;
        for (int n = 0; n < 16; n++) begin
            if (5'(n) < cmd_cdb_len) cdb_masked[8*n +: 8] = cmd_cdb[8*n +: 8];
        end
    end

    always_comb begin
        case (word_idx)
            3'd0:    cbw_word = CBW_SIG;
            3'd1:    cbw_word = tag_q;
            3'd2:    cbw_word = len_q;
            3'd3:    cbw_word = {cdb_q[7:0], 3'b000, cdb_len_q, 5'b00000, lun_q,
                                 dir_in_q ? 8'h80 : 8'h00};
            default: cbw_word = cdb_tail[{word_idx[1:0], 5'b00000} +: 32];
        endcase
    end

`ifdef MSC_HOST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            phase_act, phase_hs;

    assign phase_act = (state == S_CBW) || (state == S_DOUT) || (state == S_DIN) || (state == S_CSW);

    always_comb begin
        case (state)
            S_CBW:   phase_hs = tx_ready;
            S_DOUT:  phase_hs = wr_valid && tx_ready;
            S_DIN:   phase_hs = rx_valid && rd_ready;
            S_CSW:   phase_hs = rx_valid;
            default: phase_hs = 1'b0;
        endcase
    end

    assign to_hit = phase_act && !phase_hs && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, restarted by any progress or phase change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 to_cnt <= '0;
        else if (state_next != state || phase_hs) to_cnt <= '0;
        else if (phase_act)                      to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        tx_data       = '0;
        tx_valid      = 1'b0;
        wr_ready      = 1'b0;
        rd_data       = '0;
        rd_valid      = 1'b0;
        rx_ready      = 1'b0;
        load_result   = 1'b0;
        res_code_n    = 2'd0;
        res_residue_n = '0;
        res_status_n  = '0;
        case (state)
            S_IDLE: begin
                if (cmd_hs) begin
                    if (cmd_legal) begin
                        state_next = S_CBW;
                    end else begin
                        state_next  = S_RESULT;
                        load_result = 1'b1;
                        res_code_n  = 2'd3;
                    end
                end
            end
            S_CBW: begin
                tx_data  = cbw_word;
                tx_valid = 1'b1;
                if (tx_ready && word_idx == 3'd7)
                    state_next = (len_q == '0) ? S_CSW : (dir_in_q ? S_DIN : S_DOUT);
            end
            S_DOUT: begin
                tx_data  = wr_data;
                tx_valid = wr_valid;
                wr_ready = tx_ready;
                if (wr_valid && tx_ready && wcnt == CNT_W'(1)) state_next = S_CSW;
            end
            S_DIN: begin
                rd_data  = rx_data;
                rd_valid = rx_valid;
                rx_ready = rd_ready;
                if (rx_valid && rd_ready && wcnt == CNT_W'(1)) state_next = S_CSW;
            end
            S_CSW: begin
                rx_ready = 1'b1;
                if (rx_valid && word_idx == 3'd3) begin
                    state_next    = S_RESULT;
                    load_result   = 1'b1;
                    res_residue_n = csw_residue;
                    res_status_n  = rx_data[7:0];
                    if (sig_bad || tag_bad)                             res_code_n = 2'd3;
                    else if (rx_data[7:0] == 8'h02 || csw_residue > len_q) res_code_n = 2'd2;
                    else if (rx_data[7:0] > 8'h02)                      res_code_n = 2'd3;
                    else if (rx_data[7:0] == 8'h01)                     res_code_n = 2'd1;
                    else                                                res_code_n = 2'd0;
                end
            end
            S_RESULT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (to_hit) begin
            state_next    = S_RESULT;
            load_result   = 1'b1;
            res_code_n    = 2'd2;
            res_residue_n = {wcnt, 2'b00};
            res_status_n  = '0;
        end
    end

    // Command latch, word index, data word counter and CSW capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q       <= '0;
            len_q       <= '0;
            dir_in_q    <= 1'b0;
            lun_q       <= '0;
            cdb_len_q   <= '0;
            cdb_q       <= '0;
            wcnt        <= '0;
            word_idx    <= '0;
            sig_bad     <= 1'b0;
            tag_bad     <= 1'b0;
            csw_residue <= '0;
        end else begin
            if (cmd_hs) begin
                tag_q     <= cmd_tag;
                len_q     <= cmd_xfer_len;
                dir_in_q  <= cmd_dir_in;
                lun_q     <= cmd_lun;
                cdb_len_q <= cmd_cdb_len;
                cdb_q     <= cdb_masked;
                wcnt      <= CNT_W'((33'(cmd_xfer_len) + 33'd3) >> 2);
            end else if ((state == S_DOUT && wr_valid && tx_ready) ||
                         (state == S_DIN && rx_valid && rd_ready)) begin
                wcnt <= wcnt - CNT_W'(1);
            end
            if (state_next != state)
                word_idx <= '0;
            else if ((state == S_CBW && tx_ready) || (state == S_CSW && rx_valid))
                word_idx <= word_idx + 3'd1;
            if (state == S_CSW && rx_valid) begin
                case (word_idx)
                    3'd0:    sig_bad     <= (rx_data != CSW_SIG);
                    3'd1:    tag_bad     <= (rx_data != tag_q);
                    3'd2:    csw_residue <= rx_data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            res_valid      <= 1'b0;
            res_code       <= '0;
            res_residue    <= '0;
            res_csw_status <= '0;
        end else begin
            cmd_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
            res_valid <= (state_next == S_RESULT);
            if (load_result) begin
                res_code       <= res_code_n;
                res_residue    <= res_residue_n;
                res_csw_status <= res_status_n;
            end
        end
    end

endmodule

// File: tb/tb_msc_bbb_host.sv
// Directed self-checking bench for msc_bbb_host (CBW framing, data phases, CSW decode, reset).
module tb_msc_bbb_host;

`ifdef MSC_HOST_TIMEOUT_EN
    localparam int unsigned TO_CYC = 100;
`else
    localparam int unsigned TO_CYC = 1000000;
`endif
    localparam logic [31:0] CBW_SIG = 32'h43425355;
    localparam logic [31:0] CSW_SIG = 32'h53425355;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_dir_in;
    logic [31:0]  cmd_tag, cmd_xfer_len;
    logic [2:0]   cmd_lun;
    logic [4:0]   cmd_cdb_len;
    logic [127:0] cmd_cdb;
    logic [31:0]  tx_data, rx_data, wr_data, rd_data;
    logic         tx_valid, tx_ready, rx_valid, rx_ready;
    logic         wr_valid, wr_ready, rd_valid, rd_ready;
    logic         res_valid, busy;
    logic [1:0]   res_code;
    logic [31:0]  res_residue;
    logic [7:0]   res_csw_status;

    int          checks = 0;
    int          errors = 0;
    bit          ok;
    int          got;
    logic [31:0] cap [0:7];
    bit          r_got;
    logic [1:0]  r_code;
    logic [31:0] r_res;
    logic [7:0]  r_stat;

    msc_bbb_host #(.MAX_XFER_BYTES(65536), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
        .cmd_xfer_len(cmd_xfer_len), .cmd_dir_in(cmd_dir_in), .cmd_lun(cmd_lun),
        .cmd_cdb_len(cmd_cdb_len), .cmd_cdb(cmd_cdb),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .res_valid(res_valid), .res_code(res_code), .res_residue(res_residue),
        .res_csw_status(res_csw_status), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Drivers and monitors; every call starts and ends just after a falling edge
    task automatic issue_cmd(input logic [31:0] tag, input logic [31:0] len, input logic dir,
                             input logic [2:0] lun, input logic [4:0] cdb_len,
                             input logic [127:0] cdb, output bit accepted);
        accepted     = 1'b0;
        cmd_tag      = tag;
        cmd_xfer_len = len;
        cmd_dir_in   = dir;
        cmd_lun      = lun;
        cmd_cdb_len  = cdb_len;
        cmd_cdb      = cdb;
        cmd_valid    = 1'b1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            #1;
            if (cmd_ready) accepted = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic collect_tx(input int n, input bit stall, output int cnt);
        cnt = 0;
        for (int c = 0; c < 200 && cnt < n; c++) begin
            tx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (tx_valid && tx_ready) begin
                cap[cnt] = tx_data;
                cnt++;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic pump_dout(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < 1000 && cnt < n; c++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(c);
            tx_ready = 1'b1;
            #1;
            if (tx_valid && tx_ready) cnt++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic send_csw(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, output bit done);
        logic [31:0] w [4];
        int k;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        k = 0;
        for (int c = 0; c < 50 && k < 4; c++) begin
            rx_valid = 1'b1;
            rx_data  = w[k];
            #1;
            if (rx_ready) k++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = '0;
        done     = (k == 4);
    endtask

    task automatic wait_result(input int budget);
        r_got = 1'b0;
        for (int c = 0; c < budget && !r_got; c++) begin
            #1;
            if (res_valid) begin
                r_got  = 1'b1;
                r_code = res_code;
                r_res  = res_residue;
                r_stat = res_csw_status;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy, res_valid, tx_valid, rx_ready, wr_ready, rd_valid, res_code,
             res_residue, res_csw_status, tx_data, rd_data} !== 113'd0) begin
            errors++;
            $display("FAIL reset_outputs: got cmd_ready=%b busy=%b res_valid=%b tx_valid=%b rx_ready=%b required all 0",
                     cmd_ready, busy, res_valid, tx_valid, rx_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_tur();
        logic [31:0] exp_w [8];
        exp_w = '{CBW_SIG, 32'h1, 32'h0, 32'h00060000, 32'h0, 32'h0, 32'h0, 32'h0};
        issue_cmd(32'h1, 32'd0, 1'b0, 3'd0, 5'd6, 128'h0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tur_accept: got 0 required 1"); end
        collect_tx(8, 1'b0, got);
        checks++;
        if (got !== 8) begin errors++; $display("FAIL tur_cbw_count: got %0d required 8", got); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL tur_cbw_word%0d: got %h required %h", i, cap[i], exp_w[i]);
            end
        end
        #1;
        checks++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tur_no_data_phase: got rx_ready=%b tx_valid=%b required 1 0", rx_ready, tx_valid);
        end
        send_csw(CSW_SIG, 32'h1, 32'h0, 32'h0, ok);
        wait_result(20);
        checks++;
        if (!r_got || r_code !== 2'd0) begin
            errors++;
            $display("FAIL tur_result: got valid=%b code=%0d required 1 0", r_got, r_code);
        end
        #1;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tur_pulse_one_cycle: got res_valid=%b cmd_ready=%b busy=%b required 0 1 0",
                     res_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_inquiry_din();
        logic [31:0] exp_w [8];
        int n;
        exp_w = '{CBW_SIG, 32'h2, 32'h24, 32'h12060080, 32'h24000000, 32'h0, 32'h0, 32'h0};
        issue_cmd(32'h2, 32'd36, 1'b1, 3'd0, 5'd6, 128'h24_0000_0012, ok);
        collect_tx(8, 1'b1, got);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL inq_cbw_word%0d: got %h required %h", i, cap[i], exp_w[i]);
            end
        end
        n = 0;
        for (int c = 0; c < 100 && n < 9; c++) begin
            rd_ready = c[0];
            rx_valid = 1'b1;
            rx_data  = 32'hDEADBEEF;
            #1;
            checks++;
            if (rx_ready !== rd_ready || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL inq_passthru: got rx_ready=%b rd_valid=%b required %b 1", rx_ready, rd_valid, rd_ready);
            end
            if (rd_valid && rd_ready) begin
                n++;
                checks++;
                if (rd_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL inq_rd_data: got %h required deadbeef", rd_data);
                end
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = '0;
        rd_ready = 1'b0;
        checks++;
        if (n !== 9) begin errors++; $display("FAIL inq_count: got %0d required 9", n); end
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL inq_end_of_data: got rd_valid=%b rx_ready=%b required 0 1", rd_valid, rx_ready);
        end
        send_csw(CSW_SIG, 32'h2, 32'h0, 32'h0, ok);
        wait_result(20);
        checks++;
        if (!r_got || r_code !== 2'd0 || r_res !== 32'h0) begin
            errors++;
            $display("FAIL inq_result: got valid=%b code=%0d residue=%0d required 1 0 0", r_got, r_code, r_res);
        end
    endtask

    task automatic test_write10_dout();
        logic [31:0] exp_w [8];
        int n, mirror_bad;
        exp_w = '{CBW_SIG, 32'h3, 32'h200, 32'h2A0A0000, 32'h0, 32'h01000010, 32'h0, 32'h0};
        // bytes 10 and 15 lie beyond cdb_len and must be sent as zero
        issue_cmd(32'h3, 32'd512, 1'b0, 3'd0, 5'd10,
                  128'hEE_00_00_00_00_FF_00_01_00_00_10_00_00_00_00_2A, ok);
        collect_tx(8, 1'b1, got);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL wr10_cbw_word%0d: got %h required %h", i, cap[i], exp_w[i]);
            end
        end
        n = 0;
        mirror_bad = 0;
        for (int c = 0; c < 2000 && n < 128; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = 32'hA5000000 | 32'(n);
            tx_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (tx_valid !== wr_valid || wr_ready !== tx_ready) mirror_bad++;
            if (wr_valid && tx_ready) begin
                checks++;
                if (tx_data !== (32'hA5000000 | 32'(n))) begin
                    errors++;
                    $display("FAIL wr10_tx_data: got %h required %h", tx_data, 32'hA5000000 | 32'(n));
                end
                n++;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        checks++;
        if (n !== 128) begin errors++; $display("FAIL wr10_count: got %0d required 128", n); end
        checks++;
        if (mirror_bad !== 0) begin errors++; $display("FAIL wr10_valid_ready: got %0d bad cycles required 0", mirror_bad); end
        #1;
        checks++;
        if (rx_ready !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr10_end_of_data: got rx_ready=%b wr_ready=%b required 1 0", rx_ready, wr_ready);
        end
        send_csw(CSW_SIG, 32'h3, 32'h0, 32'h1, ok);
        wait_result(20);
        checks++;
        if (!r_got || r_code !== 2'd1 || r_stat !== 8'h01) begin
            errors++;
            $display("FAIL wr10_result: got valid=%b code=%0d status=%h required 1 1 01", r_got, r_code, r_stat);
        end
    endtask

    task automatic test_csw_decode();
        logic [31:0] sig_t [9];
        logic [31:0] res_t [9];
        logic [31:0] st_t  [9];
        bit          badtag_t [9];
        logic [1:0]  exp_t [9];
        logic [31:0] tag;
        sig_t    = '{CSW_SIG, 32'hBADC0FFE, CSW_SIG, CSW_SIG, CSW_SIG, CSW_SIG, 32'hBADC0FFE, CSW_SIG, CSW_SIG};
        badtag_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        res_t    = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
        st_t     = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h3, 32'h0, 32'h2, 32'h1, 32'h12345601};
        exp_t    = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 9; i++) begin
            tag = 32'h100 + 32'(i);
            issue_cmd(tag, 32'd0, 1'b0, 3'd5, 5'd6, 128'h0, ok);
            collect_tx(8, 1'b0, got);
            send_csw(sig_t[i], badtag_t[i] ? (tag ^ 32'h1) : tag, res_t[i], st_t[i], ok);
            wait_result(20);
            checks++;
            if (!r_got || r_code !== exp_t[i]) begin
                errors++;
                $display("FAIL csw_code_vec%0d: got valid=%b code=%0d required 1 %0d", i, r_got, r_code, exp_t[i]);
            end
            checks++;
            if (r_res !== res_t[i] || r_stat !== st_t[i][7:0]) begin
                errors++;
                $display("FAIL csw_fields_vec%0d: got residue=%0d status=%h required %0d %h",
                         i, r_res, r_stat, res_t[i], st_t[i][7:0]);
            end
        end
    endtask

    task automatic test_phase_residue();
        logic [31:0] csw_res [2];
        logic [1:0]  exp_c [2];
        csw_res = '{32'd600, 32'd512};
        exp_c   = '{2'd2, 2'd0};
        for (int i = 0; i < 2; i++) begin
            issue_cmd(32'h20 + 32'(i), 32'd512, 1'b0, 3'd0, 5'd10, 128'h2A, ok);
            collect_tx(8, 1'b0, got);
            pump_dout(128, got);
            checks++;
            if (got !== 128) begin errors++; $display("FAIL residue_pump%0d: got %0d required 128", i, got); end
            send_csw(CSW_SIG, 32'h20 + 32'(i), csw_res[i], 32'h0, ok);
            wait_result(20);
            checks++;
            if (!r_got || r_code !== exp_c[i] || r_res !== csw_res[i]) begin
                errors++;
                $display("FAIL residue_vec%0d: got valid=%b code=%0d residue=%0d required 1 %0d %0d",
                         i, r_got, r_code, r_res, exp_c[i], csw_res[i]);
            end
        end
    endtask

    task automatic test_reset_mid_din();
        int pulses;
        issue_cmd(32'h7, 32'd65536, 1'b1, 3'd0, 5'd10, 128'h28, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL max_len_accept: got 0 required 1"); end
        collect_tx(8, 1'b0, got);
        checks++;
        if (cap[2] !== 32'h00010000 || cap[3] !== 32'h280A0080) begin
            errors++;
            $display("FAIL max_len_cbw: got %h %h required 00010000 280a0080", cap[2], cap[3]);
        end
        for (int c = 0; c < 3; c++) begin
            rx_valid = 1'b1;
            rx_data  = 32'h11110000 | 32'(c);
            rd_ready = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy, res_valid, tx_valid, rx_ready, wr_ready, rd_valid, res_code,
             res_residue, res_csw_status, tx_data, rd_data} !== 113'd0) begin
            errors++;
            $display("FAIL din_reset_outputs: got busy=%b rd_valid=%b rx_ready=%b res_residue=%0d required all 0",
                     busy, rd_valid, rx_ready, res_residue);
        end
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (res_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL din_reset_no_result: got %0d pulses required 0", pulses); end
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL din_reset_idle: got cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_illegal();
        logic [4:0]  cl_t [3];
        logic [31:0] len_t [3];
        cl_t  = '{5'd0, 5'd17, 5'd6};
        len_t = '{32'd0, 32'd0, 32'd65537};
        for (int i = 0; i < 3; i++) begin
            issue_cmd(32'h30 + 32'(i), len_t[i], 1'b0, 3'd0, cl_t[i], 128'h12, ok);
            #1;
            checks++;
            if (tx_valid !== 1'b0 || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
                errors++;
                $display("FAIL illegal_vec%0d_state: got tx_valid=%b cmd_ready=%b res_valid=%b required 0 0 1",
                         i, tx_valid, cmd_ready, res_valid);
            end
            wait_result(5);
            checks++;
            if (!r_got || r_code !== 2'd3) begin
                errors++;
                $display("FAIL illegal_vec%0d_code: got valid=%b code=%0d required 1 3", i, r_got, r_code);
            end
            #1;
            checks++;
            if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_vec%0d_after: got tx_valid=%b cmd_ready=%b required 0 1", i, tx_valid, cmd_ready);
            end
        end
    endtask

`ifdef MSC_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int wait_cyc;
        issue_cmd(32'h9, 32'd0, 1'b0, 3'd0, 5'd6, 128'h0, ok);
        collect_tx(8, 1'b0, got);
        r_got    = 1'b0;
        wait_cyc = 0;
        for (int c = 0; c < 300 && !r_got; c++) begin
            #1;
            if (res_valid) begin
                r_got    = 1'b1;
                r_code   = res_code;
                r_res    = res_residue;
                wait_cyc = c;
            end
            @(negedge clk);
        end
        checks++;
        if (!r_got || r_code !== 2'd2 || r_res !== 32'd0) begin
            errors++;
            $display("FAIL timeout_result: got valid=%b code=%0d residue=%0d required 1 2 0", r_got, r_code, r_res);
        end
        checks++;
        if (wait_cyc !== 100) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles required 100", wait_cyc);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_tag      = '0;
        cmd_xfer_len = '0;
        cmd_dir_in   = 1'b0;
        cmd_lun      = '0;
        cmd_cdb_len  = '0;
        cmd_cdb      = '0;
        tx_ready     = 1'b0;
        rx_data      = '0;
        rx_valid     = 1'b0;
        wr_data      = '0;
        wr_valid     = 1'b0;
        rd_ready     = 1'b0;
        test_reset();
        test_tur();
        test_inquiry_din();
        test_write10_dout();
        test_csw_decode();
        test_phase_residue();
        test_illegal();
`ifdef MSC_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_din();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
